// File: rtl/imm_gen_pipe_if.sv
// Handshake/result bundle for imm_gen_pipe.
// slave: the decoder side; master: the fetch/execute side driving it.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a two-entry skid buffer and a
// saturating illegal-opcode counter.
// Optional feature: define IMM_GEN_ZICSR_EN to decode SYSTEM opcodes (CSR
// immediate forms as format Z, register forms as format I); otherwise SYSTEM
// is treated as illegal.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  imm_gen_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [31:0]        instr;
  logic signed [31:0] imm32;
  entry_t             dec;
  entry_t             main_q, main_d, skid_q, skid_d;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_xfer, out_xfer, main_free;

  assign instr     = bus.in_instr;
  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign out_xfer  = main_valid_q && bus.out_ready;
  assign main_free = !main_valid_q || out_xfer;

  // Classify the opcode and assemble a 32-bit immediate; the signed cast widens it to XLEN.
  always_comb begin
    imm32       = '0;
    dec.fmt     = FmtNone;
    dec.illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec.fmt = FmtI;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            dec.fmt = FmtI;
            imm32   = {{20{instr[31]}}, instr[31:20]};
          end
        end
        7'b0100011: begin
          dec.fmt = FmtS;
          imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FmtB;
          imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FmtU;
          imm32   = {instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FmtJ;
          imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
`ifdef IMM_GEN_ZICSR_EN
        7'b1110011: begin
          if (instr[14]) begin
            dec.fmt = FmtZ;
            imm32   = {27'b0, instr[19:15]};
          end else begin
            dec.fmt = FmtI;
            imm32   = {{20{instr[31]}}, instr[31:20]};
          end
        end
`endif
        default: dec.fmt = FmtNone;
      endcase
      dec.illegal = (dec.fmt == FmtNone);
    end
    dec.imm = XLEN'(imm32);
  end

  // Main/skid steering and illegal-count next state.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (main_free) begin
      // in_ready is low whenever the skid holds data, so no input can arrive here then.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) begin
          main_d = dec;
        end
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    if (in_xfer && dec.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: three instances (RV32, RV64, RV32 with a 2-bit counter) share
// one stimulus stream; each is checked against hand-computed values.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IMM_GEN_ZICSR_EN
  localparam logic [31:0] CsrImm = 32'h1;
  localparam logic [2:0]  CsrFmt = 3'd6;
  localparam logic        CsrIll = 1'b0;
`else
  localparam logic [31:0] CsrImm = 32'h0;
  localparam logic [2:0]  CsrFmt = 3'd0;
  localparam logic        CsrIll = 1'b1;
`endif

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(16)) if64 ();
  imm_gen_pipe_if #(.XLEN(32), .CNT_W(2))  ifc2 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = in_instr;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = in_instr;
  assign if64.out_ready = out_ready;
  assign ifc2.in_valid  = in_valid;
  assign ifc2.in_instr  = in_instr;
  assign ifc2.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));
  imm_gen_pipe #(.XLEN(32), .CNT_W(2))  u_dutc2 (.clk(clk), .rst(rst), .bus(ifc2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
    in_valid = 1'b0;
  endtask

  // Send one word with out_ready high and check both XLEN variants next cycle.
  task automatic vec(input string tag, input logic [31:0] w,
                     input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                     input logic [63:0] i64, input logic [2:0] f64, input logic l64);
    send(w);
    check({tag, ".v32"},   64'(if32.out_valid),   64'd1);
    check({tag, ".imm32"}, 64'(if32.out_imm),     64'(i32));
    check({tag, ".fmt32"}, 64'(if32.out_fmt),     64'(f32));
    check({tag, ".ill32"}, 64'(if32.out_illegal), 64'(l32));
    check({tag, ".rdy32"}, 64'(if32.in_ready),    64'd1);
    check({tag, ".imm64"}, if64.out_imm,          i64);
    check({tag, ".fmt64"}, 64'(if64.out_fmt),     64'(f64));
    check({tag, ".ill64"}, 64'(if64.out_illegal), 64'(l64));
  endtask

  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst.valid",  64'(if32.out_valid),   64'd0);
    check("rst.imm",    64'(if32.out_imm),     64'd0);
    check("rst.fmt",    64'(if32.out_fmt),     64'd0);
    check("rst.ill",    64'(if32.out_illegal), 64'd0);
    check("rst.cnt",    64'(if32.illegal_cnt), 64'd0);
    check("rst.ready",  64'(if32.in_ready),    64'd1);

    // Back-to-back decode, one word per cycle.
    vec("addi", 32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    vec("beq",  32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    vec("lui",  32'h1234_52B7, 32'h1234_5000, 3'd4, 1'b0, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    vec("luin", 32'h8000_02B7, 32'h8000_0000, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    vec("sw",   32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    vec("jal",  32'h0080_006F, 32'h0000_0008, 3'd5, 1'b0, 64'h0000_0000_0000_0008, 3'd5, 1'b0);
    vec("low2", 32'h0000_0010, 32'h0000_0000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
    vec("addiw", 32'h0010_009B, 32'h0000_0000, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0);
    check("cnt32.after_addiw", 64'(if32.illegal_cnt), 64'd2);
    check("cnt64.after_addiw", 64'(if64.illegal_cnt), 64'd1);
    vec("csrrwi", 32'h3400_D073, CsrImm, CsrFmt, CsrIll, 64'(CsrImm), CsrFmt, CsrIll);
    check("cnt64.after_csr", 64'(if64.illegal_cnt), 64'd1 + 64'(CsrIll));
    step();
    check("drain.valid", 64'(if32.out_valid), 64'd0);

    // Backpressure: two words fit, third waits until the skid drains.
    out_ready = 1'b0;
    send(32'h0010_0093);
    check("bp.rdy_after1", 64'(if32.in_ready), 64'd1);
    send(32'h0020_0093);
    check("bp.rdy_after2", 64'(if32.in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h0030_0093;
    step();
    check("bp.rdy_hold",  64'(if32.in_ready), 64'd0);
    check("bp.hold_imm",  64'(if32.out_imm),  64'd1);
    out_ready = 1'b1;
    step();
    check("bp.w2_imm", 64'(if32.out_imm),  64'd2);
    check("bp.w2_rdy", 64'(if32.in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp.w3_imm",   64'(if32.out_imm),   64'd3);
    check("bp.w3_valid", 64'(if32.out_valid), 64'd1);
    step();
    check("bp.empty", 64'(if32.out_valid), 64'd0);

    // Counter saturation on the 2-bit instance.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_007F);
      check($sformatf("sat.c2[%0d]", i), 64'(ifc2.illegal_cnt), 64'(sat_exp[i]));
      check($sformatf("sat.c16[%0d]", i), 64'(if32.illegal_cnt), 64'(i + 1));
    end

    // Reset mid-stream with both entries full and input still offered.
    out_ready = 1'b0;
    send(32'h0010_0093);
    send(32'h0020_0093);
    check("mid.full_rdy", 64'(if32.in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h0000_007F;
    rst = 1'b1;
    step();
    check("mid.valid", 64'(if32.out_valid),   64'd0);
    check("mid.ready", 64'(if32.in_ready),    64'd1);
    check("mid.cnt",   64'(ifc2.illegal_cnt), 64'd0);
    check("mid.imm",   64'(if32.out_imm),     64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("mid.after", 64'(if32.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage. Takes a full 32-bit instruction word, classifies its immediate format, and produces a correctly sign-extended XLEN-bit immediate, a format code and an illegal flag. Input and output use valid/ready handshakes, with a two-entry skid buffer so that fetch and execute may stall independently. A saturating counter records how many illegal opcodes have been seen.

## Interface

Parameters:
- XLEN, 32: immediate width; legal values are 32 and 64.
- CNT_W, 16: width of the illegal-opcode counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_illegal  out  1  opcode is not recognised.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal words.

## Operation

- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Decode works on opcode = instr[6:0]. Every immediate is sign-extended from instr[31] to XLEN.
- I format:
  - Opcodes 0000011, 0010011 and 1100111.
  - Opcode 0011011 only when XLEN==64.
  - imm = instr[31:20].
- S format: opcode 0100011; imm = {instr[31:25], instr[11:7]}.
- B format: opcode 1100011; imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U format: opcodes 0110111 and 0010111; imm = {instr[31:12], 12'b0}, sign-extended when XLEN==64.
- J format: opcode 1101111; imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Any other opcode, or instr[1:0] != 2'b11:
  - out_fmt = NONE, out_imm = 0, out_illegal = 1.
  - illegal_cnt increments on the input transfer and saturates at all-ones.
- Storage is a main output register plus one skid register. Both hold {imm, fmt, illegal}.
- Word ordering is strict FIFO. No word is ever dropped or duplicated.
- When the main register is empty, or is emptying this cycle, the new word goes to the main register. Otherwise it goes to the skid register.
- When the main register empties, the skid contents move into it on the same edge.

## Timing

- Reset values:
  - out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0.
  - illegal_cnt = 0.
  - in_ready = 1.
  - Skid register is empty.
- Latency: an input transfer in cycle N gives out_valid = 1 with that result in cycle N+1.
- Throughput: one word per cycle while out_ready is held high.
- in_ready is registered: in_ready = !skid_full.
  - in_ready goes low the cycle after the skid fills.
  - in_ready returns high the cycle after the skid drains.
- Out register is full, skid is empty, and input and output transfers happen in the same cycle: the new word goes straight to the main register and the skid stays empty.
- out_valid && !out_ready: out_imm, out_fmt and out_illegal hold stable until the transfer.
- rst asserted mid-stream: both buffered entries are discarded and all outputs return to their reset values on the next edge. The handshake inputs are ignored in the reset cycle.
- illegal_cnt at all-ones together with another illegal input: the count stays at all-ones.

## Configuration

- IMM_GEN_ZICSR_EN defined:
  - Opcode 1110011 with funct3[2] = 1 decodes as format Z.
  - imm = zero-extended instr[19:15].
  - Opcode 1110011 with funct3[2] = 0 decodes as format I.
- IMM_GEN_ZICSR_EN undefined: opcode 1110011 is illegal and is counted.

## Test plan

- XLEN=32; send 0xFFF00093 (ADDI x1, x0, -1) -> next cycle out_imm = 0xFFFFFFFF, out_fmt = 1, out_illegal = 0.
- Send 0xFE000EE3 (BEQ x0, x0, -4) -> out_imm = 0xFFFFFFFC, out_fmt = 3. Send 0x123452B7 (LUI) -> out_imm = 0x12345000, out_fmt = 4.
- XLEN=64; send 0x800002B7 -> out_imm = 0xFFFFFFFF80000000. Send 0x0010009B (ADDIW) -> out_imm = 1, out_fmt = 1. With XLEN=32, 0x0010009B -> out_illegal = 1.
- Backpressure:
  - Hold out_ready = 0 and stream 3 words -> first two accepted, in_ready = 0 from the cycle after the second acceptance.
  - Release out_ready -> words delivered in order with no loss and no duplicates.
- Send 0x0000007F with CNT_W = 2, five times -> illegal_cnt reads 1, 2, 3, 3, 3. Assert rst -> illegal_cnt = 0, out_valid = 0, in_ready = 1 on the next edge.
- Send 0x3400D073 (CSRRWI) -> with IMM_GEN_ZICSR_EN, out_fmt = 6 and out_imm = 1. Without the macro, out_illegal = 1.
